// File: rtl/id_ex_stage_pkg.sv
// Shared types and constants for the ID/EX pipeline register and its
// operand forwarding muxes.
package id_ex_stage_pkg;

  // Default datapath and register-specifier widths.
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  // ALU operation encoding consumed by the EX-stage ALU.
  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_NOR = 4'd3,
    ALU_OR  = 4'd4,
    ALU_SLT = 4'd5,
    ALU_XOR = 4'd6
  } alu_op_e;

  // Control bundle carried from decode into EX. The op is kept as raw bits
  // so an undefined decode value passes through untouched.
  typedef struct packed {
    logic [3:0]       alu_ctl;
    logic             alusrc;
    logic             regwrite;
    logic             memread;
    logic             memwrite;
    logic             memtoreg;
    logic [REG_W-1:0] rd;
  } idex_ctl_t;

  // Control of an empty slot: no side effects, ADD op, destination $0.
  localparam idex_ctl_t BUBBLE = '{
    alu_ctl:  ALU_ADD,
    alusrc:   1'b0,
    regwrite: 1'b0,
    memread:  1'b0,
    memwrite: 1'b0,
    memtoreg: 1'b0,
    rd:       {REG_W{1'b0}}
  };

  // A later stage supplies the value of reg_spec when it writes that
  // register and the register is not the hardwired $0.
  function automatic logic fwd_hit(input logic             wr,
                                   input logic [REG_W-1:0] src_rd,
                                   input logic [REG_W-1:0] reg_spec);
    return wr & (src_rd != {REG_W{1'b0}}) & (src_rd == reg_spec);
  endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Single-operand forwarding select: EX/MEM result, then MEM/WB result,
// then the register-file value captured at decode.
module id_ex_stage_fwd_mux
  import id_ex_stage_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int RW = REG_W
) (
  input  logic [RW-1:0] reg_i,
  input  logic [DW-1:0] rf_data_i,
  input  logic          exmem_regwrite_i,
  input  logic [RW-1:0] exmem_rd_i,
  input  logic [DW-1:0] exmem_result_i,
  input  logic          memwb_regwrite_i,
  input  logic [RW-1:0] memwb_rd_i,
  input  logic [DW-1:0] memwb_result_i,
  output logic [DW-1:0] data_o
);

  // Youngest producer wins, so EX/MEM is checked before MEM/WB.
  always_comb begin
    data_o = rf_data_i;
    if (fwd_hit(exmem_regwrite_i, exmem_rd_i, reg_i)) begin
      data_o = exmem_result_i;
    end else if (fwd_hit(memwb_regwrite_i, memwb_rd_i, reg_i)) begin
      data_o = memwb_result_i;
    end else begin
      data_o = rf_data_i;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded operands and control, forwards
// later-stage results onto the ALU operands and raises the load-use stall.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int RW = REG_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          hold,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [3:0]    id_alu_ctl,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic          id_alusrc,
  input  logic          id_uses_rt,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic          id_regwrite,
  input  logic          id_memread,
  input  logic          id_memwrite,
  input  logic          id_memtoreg,
  input  logic          exmem_regwrite,
  input  logic [RW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_regwrite,
  input  logic [RW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_result,
  output logic          load_use_stall,
  output logic          ex_valid,
  output logic [3:0]    ex_alu_ctl,
  output logic [DW-1:0] ex_a,
  output logic [DW-1:0] ex_b,
  output logic [DW-1:0] ex_store_data,
  output logic [RW-1:0] ex_rd,
  output logic          ex_regwrite,
  output logic          ex_memread,
  output logic          ex_memwrite,
  output logic          ex_memtoreg
);

  idex_ctl_t     ctl_q,     ctl_d;
  logic          valid_q,   valid_d;
  logic [RW-1:0] rs_q,      rs_d;
  logic [RW-1:0] rt_q,      rt_d;
  logic [DW-1:0] rs_data_q, rs_data_d;
  logic [DW-1:0] rt_data_q, rt_data_d;
  logic [DW-1:0] imm_q,     imm_d;
  logic [DW-1:0] fwd_rs;
  logic [DW-1:0] fwd_rt;

  // Stall decode when the load in EX targets a register the next
  // instruction reads; a frozen pipeline never requests a stall.
  always_comb begin
    load_use_stall = 1'b0;
    if (hold) begin
      load_use_stall = 1'b0;
    end else begin
      load_use_stall = valid_q & ctl_q.memread & id_valid
                     & (ctl_q.rd != {RW{1'b0}})
                     & ((ctl_q.rd == id_rs) | (id_uses_rt & (ctl_q.rd == id_rt)));
    end
  end

  // Next slot contents: flush beats hold, hold beats the load-use bubble.
  always_comb begin
    ctl_d     = ctl_q;
    valid_d   = valid_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    if (flush || (!hold && load_use_stall)) begin
      ctl_d     = BUBBLE;
      valid_d   = 1'b0;
      rs_d      = {RW{1'b0}};
      rt_d      = {RW{1'b0}};
      rs_data_d = {DW{1'b0}};
      rt_data_d = {DW{1'b0}};
      imm_d     = {DW{1'b0}};
    end else if (hold) begin
      ctl_d     = ctl_q;
      valid_d   = valid_q;
    end else begin
      // An invalid slot is captured but can never write anything.
      ctl_d.alu_ctl  = id_alu_ctl;
      ctl_d.alusrc   = id_alusrc;
      ctl_d.regwrite = id_regwrite & id_valid;
      ctl_d.memread  = id_memread  & id_valid;
      ctl_d.memwrite = id_memwrite & id_valid;
      ctl_d.memtoreg = id_memtoreg & id_valid;
      ctl_d.rd       = id_rd;
      valid_d        = id_valid;
      rs_d           = id_rs;
      rt_d           = id_rt;
      rs_data_d      = id_rs_data;
      rt_data_d      = id_rt_data;
      imm_d          = id_imm;
    end
  end

  // Pipeline register with asynchronous clear to an empty slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_q     <= BUBBLE;
      valid_q   <= 1'b0;
      rs_q      <= {RW{1'b0}};
      rt_q      <= {RW{1'b0}};
      rs_data_q <= {DW{1'b0}};
      rt_data_q <= {DW{1'b0}};
      imm_q     <= {DW{1'b0}};
    end else begin
      ctl_q     <= ctl_d;
      valid_q   <= valid_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
    end
  end

  id_ex_stage_fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rs (
    .reg_i            (rs_q),
    .rf_data_i        (rs_data_q),
    .exmem_regwrite_i (exmem_regwrite),
    .exmem_rd_i       (exmem_rd),
    .exmem_result_i   (exmem_result),
    .memwb_regwrite_i (memwb_regwrite),
    .memwb_rd_i       (memwb_rd),
    .memwb_result_i   (memwb_result),
    .data_o           (fwd_rs)
  );

  id_ex_stage_fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rt (
    .reg_i            (rt_q),
    .rf_data_i        (rt_data_q),
    .exmem_regwrite_i (exmem_regwrite),
    .exmem_rd_i       (exmem_rd),
    .exmem_result_i   (exmem_result),
    .memwb_regwrite_i (memwb_regwrite),
    .memwb_rd_i       (memwb_rd),
    .memwb_result_i   (memwb_result),
    .data_o           (fwd_rt)
  );

  assign ex_valid      = valid_q;
  assign ex_alu_ctl    = ctl_q.alu_ctl;
  assign ex_rd         = ctl_q.rd;
  assign ex_regwrite   = ctl_q.regwrite;
  assign ex_memread    = ctl_q.memread;
  assign ex_memwrite   = ctl_q.memwrite;
  assign ex_memtoreg   = ctl_q.memtoreg;
  assign ex_a          = fwd_rs;
  assign ex_store_data = fwd_rt;
  assign ex_b          = ctl_q.alusrc ? imm_q : fwd_rt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vector table, hand-written
// hazard/hold/flush/reset sequences, then random traffic against a model.
module tb_id_ex_stage;

  logic        clk, rst_n, hold, flush, id_valid;
  logic [3:0]  id_alu_ctl;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic        id_alusrc, id_uses_rt;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_regwrite, id_memread, id_memwrite, id_memtoreg;
  logic        exmem_regwrite, memwb_regwrite;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic        load_use_stall, ex_valid;
  logic [3:0]  ex_alu_ctl;
  logic [31:0] ex_a, ex_b, ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;

  int checks = 0;
  int errors = 0;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush), .id_valid(id_valid),
    .id_alu_ctl(id_alu_ctl), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_alusrc(id_alusrc), .id_uses_rt(id_uses_rt),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .load_use_stall(load_use_stall), .ex_valid(ex_valid), .ex_alu_ctl(ex_alu_ctl),
    .ex_a(ex_a), .ex_b(ex_b), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_memtoreg(ex_memtoreg)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [3:0] ctl; logic [4:0] rs; logic [4:0] rt;
    logic [31:0] rsd; logic [31:0] rtd; logic [31:0] imm;
    logic src; logic vld; logic rw;
    logic xw; logic [4:0] xrd; logic [31:0] xres;
    logic ww; logic [4:0] wrd; logic [31:0] wres;
    logic [31:0] ea; logic [31:0] eb; logic [31:0] es;
    logic [3:0] ectl; logic ev; logic erw;
  } vec_t;

  vec_t vecs[7];

  // Model of the EX slot: what the instruction now in EX looks like.
  typedef struct {
    logic valid; logic [3:0] op; logic src;
    logic rw; logic mr; logic mw; logic mtr;
    logic [4:0] rd; logic [4:0] rs; logic [4:0] rt;
    logic [31:0] rsd; logic [31:0] rtd; logic [31:0] imm;
  } slot_t;

  slot_t m;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clear_inputs();
    hold = 1'b0; flush = 1'b0; id_valid = 1'b0; id_alu_ctl = 4'd0;
    id_rs_data = 32'd0; id_rt_data = 32'd0; id_imm = 32'd0;
    id_alusrc = 1'b0; id_uses_rt = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd0;
    id_regwrite = 1'b0; id_memread = 1'b0; id_memwrite = 1'b0; id_memtoreg = 1'b0;
    exmem_regwrite = 1'b0; exmem_rd = 5'd0; exmem_result = 32'd0;
    memwb_regwrite = 1'b0; memwb_rd = 5'd0; memwb_result = 32'd0;
  endtask

  function automatic logic [31:0] model_fwd(input logic [4:0] r, input logic [31:0] rf);
    if (exmem_regwrite && exmem_rd != 5'd0 && exmem_rd == r) return exmem_result;
    if (memwb_regwrite && memwb_rd != 5'd0 && memwb_rd == r) return memwb_result;
    return rf;
  endfunction

  function automatic logic model_stall();
    if (hold || !id_valid || !m.valid || !m.mr || m.rd == 5'd0) return 1'b0;
    return (m.rd == id_rs) || (id_uses_rt && m.rd == id_rt);
  endfunction

  function automatic slot_t empty_slot();
    slot_t s;
    s = '{valid: 1'b0, op: 4'd0, src: 1'b0, rw: 1'b0, mr: 1'b0, mw: 1'b0, mtr: 1'b0,
          rd: 5'd0, rs: 5'd0, rt: 5'd0, rsd: 32'd0, rtd: 32'd0, imm: 32'd0};
    return s;
  endfunction

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    #12;
    // Reset state before any load.
    chk("rst_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_ctl", {28'd0, ex_alu_ctl}, 32'd0);
    chk("rst_a", ex_a, 32'd0);
    rst_n = 1'b1;
    tick();

    // ---------------- directed vector table ----------------
    vecs[0] = '{ctl:4'd1, rs:5'd1, rt:5'd2, rsd:32'd5, rtd:32'd7, imm:32'd0, src:1'b0, vld:1'b1, rw:1'b1,
                xw:1'b0, xrd:5'd0, xres:32'd0, ww:1'b0, wrd:5'd0, wres:32'd0,
                ea:32'd5, eb:32'd7, es:32'd7, ectl:4'd1, ev:1'b1, erw:1'b1};
    vecs[1] = '{ctl:4'd0, rs:5'd3, rt:5'd4, rsd:32'h99, rtd:32'h44, imm:32'd0, src:1'b0, vld:1'b1, rw:1'b1,
                xw:1'b1, xrd:5'd3, xres:32'h11, ww:1'b1, wrd:5'd3, wres:32'h22,
                ea:32'h11, eb:32'h44, es:32'h44, ectl:4'd0, ev:1'b1, erw:1'b1};
    vecs[2] = '{ctl:4'd0, rs:5'd3, rt:5'd4, rsd:32'h99, rtd:32'h44, imm:32'd0, src:1'b0, vld:1'b1, rw:1'b1,
                xw:1'b1, xrd:5'd0, xres:32'h11, ww:1'b1, wrd:5'd3, wres:32'h22,
                ea:32'h22, eb:32'h44, es:32'h44, ectl:4'd0, ev:1'b1, erw:1'b1};
    vecs[3] = '{ctl:4'd0, rs:5'd1, rt:5'd6, rsd:32'h10, rtd:32'h1, imm:32'hFFFFFFFC, src:1'b1, vld:1'b1, rw:1'b1,
                xw:1'b0, xrd:5'd6, xres:32'h77, ww:1'b1, wrd:5'd6, wres:32'hAB,
                ea:32'h10, eb:32'hFFFFFFFC, es:32'hAB, ectl:4'd0, ev:1'b1, erw:1'b1};
    vecs[4] = '{ctl:4'd4, rs:5'd0, rt:5'd0, rsd:32'h5A, rtd:32'h3C, imm:32'd0, src:1'b0, vld:1'b1, rw:1'b1,
                xw:1'b1, xrd:5'd0, xres:32'hDEAD, ww:1'b1, wrd:5'd0, wres:32'hBEEF,
                ea:32'h5A, eb:32'h3C, es:32'h3C, ectl:4'd4, ev:1'b1, erw:1'b1};
    vecs[5] = '{ctl:4'd5, rs:5'd2, rt:5'd3, rsd:32'h1, rtd:32'h2, imm:32'd0, src:1'b0, vld:1'b0, rw:1'b1,
                xw:1'b1, xrd:5'd2, xres:32'h55, ww:1'b0, wrd:5'd0, wres:32'd0,
                ea:32'h55, eb:32'h2, es:32'h2, ectl:4'd5, ev:1'b0, erw:1'b0};
    vecs[6] = '{ctl:4'd3, rs:5'd7, rt:5'd7, rsd:32'h1, rtd:32'h1, imm:32'd0, src:1'b0, vld:1'b1, rw:1'b1,
                xw:1'b1, xrd:5'd7, xres:32'hCAFE, ww:1'b1, wrd:5'd7, wres:32'hF00D,
                ea:32'hCAFE, eb:32'hCAFE, es:32'hCAFE, ectl:4'd3, ev:1'b1, erw:1'b1};

    for (int i = 0; i < 7; i++) begin
      clear_inputs();
      id_alu_ctl = vecs[i].ctl; id_rs = vecs[i].rs; id_rt = vecs[i].rt; id_rd = 5'd9;
      id_rs_data = vecs[i].rsd; id_rt_data = vecs[i].rtd; id_imm = vecs[i].imm;
      id_alusrc = vecs[i].src; id_valid = vecs[i].vld; id_regwrite = vecs[i].rw;
      tick();
      id_valid = 1'b0;
      exmem_regwrite = vecs[i].xw; exmem_rd = vecs[i].xrd; exmem_result = vecs[i].xres;
      memwb_regwrite = vecs[i].ww; memwb_rd = vecs[i].wrd; memwb_result = vecs[i].wres;
      settle();
      chk($sformatf("v%0d_a", i), ex_a, vecs[i].ea);
      chk($sformatf("v%0d_b", i), ex_b, vecs[i].eb);
      chk($sformatf("v%0d_store", i), ex_store_data, vecs[i].es);
      chk($sformatf("v%0d_ctl", i), {28'd0, ex_alu_ctl}, {28'd0, vecs[i].ectl});
      chk($sformatf("v%0d_valid", i), {31'd0, ex_valid}, {31'd0, vecs[i].ev});
      chk($sformatf("v%0d_regwrite", i), {31'd0, ex_regwrite}, {31'd0, vecs[i].erw});
    end

    // ---------------- load-use hazard ----------------
    clear_inputs();
    id_valid = 1'b1; id_memread = 1'b1; id_regwrite = 1'b1; id_memtoreg = 1'b1;
    id_rd = 5'd8; id_rs = 5'd1; id_rt = 5'd2;
    tick();
    id_memread = 1'b0; id_memtoreg = 1'b0; id_rd = 5'd10;
    id_rs = 5'd8; id_rt = 5'd9; id_uses_rt = 1'b1;
    settle();
    chk("lu_rs_stall", {31'd0, load_use_stall}, 32'd1);
    tick();
    chk("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
    chk("lu_bubble_regwrite", {31'd0, ex_regwrite}, 32'd0);
    chk("lu_bubble_rd", {27'd0, ex_rd}, 32'd0);
    chk("lu_after_bubble_stall", {31'd0, load_use_stall}, 32'd0);
    tick();
    id_memread = 1'b1; id_memtoreg = 1'b1; id_rd = 5'd8; id_rs = 5'd1; id_rt = 5'd2;
    tick();
    id_memread = 1'b0; id_memtoreg = 1'b0; id_rd = 5'd10;
    id_rs = 5'd9; id_rt = 5'd8; id_uses_rt = 1'b0;
    settle();
    chk("lu_rt_unused_stall", {31'd0, load_use_stall}, 32'd0);
    id_uses_rt = 1'b1;
    settle();
    chk("lu_rt_used_stall", {31'd0, load_use_stall}, 32'd1);
    hold = 1'b1;
    settle();
    chk("lu_hold_stall", {31'd0, load_use_stall}, 32'd0);

    // ---------------- hold and flush ----------------
    clear_inputs();
    id_valid = 1'b1; id_alu_ctl = 4'd6; id_rs = 5'd5; id_rt = 5'd6; id_rd = 5'd7;
    id_rs_data = 32'h1234; id_rt_data = 32'h5678; id_regwrite = 1'b1;
    tick();
    hold = 1'b1; id_alu_ctl = 4'd2; id_rs_data = 32'hFFFF; id_rt_data = 32'hEEEE; id_rd = 5'd3;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("hold%0d_a", c), ex_a, 32'h1234);
      chk($sformatf("hold%0d_b", c), ex_b, 32'h5678);
      chk($sformatf("hold%0d_ctl", c), {28'd0, ex_alu_ctl}, 32'd6);
      chk($sformatf("hold%0d_rd", c), {27'd0, ex_rd}, 32'd7);
    end
    flush = 1'b1;
    tick();
    chk("holdflush_valid", {31'd0, ex_valid}, 32'd0);
    chk("holdflush_ctl", {28'd0, ex_alu_ctl}, 32'd0);
    chk("holdflush_regwrite", {31'd0, ex_regwrite}, 32'd0);
    chk("holdflush_a", ex_a, 32'd0);

    // ---------------- asynchronous reset mid-stream ----------------
    clear_inputs();
    id_valid = 1'b1; id_alu_ctl = 4'd1; id_rs = 5'd4; id_rt = 5'd5; id_rd = 5'd6;
    id_rs_data = 32'hAAAA; id_rt_data = 32'hBBBB; id_regwrite = 1'b1; id_memread = 1'b1;
    tick();
    chk("pre_rst_valid", {31'd0, ex_valid}, 32'd1);
    id_rs = 5'd6;
    exmem_regwrite = 1'b1; exmem_rd = 5'd4; exmem_result = 32'h4444;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_mid_ctl", {28'd0, ex_alu_ctl}, 32'd0);
    chk("rst_mid_a", ex_a, 32'd0);
    chk("rst_mid_b", ex_b, 32'd0);
    chk("rst_mid_store", ex_store_data, 32'd0);
    chk("rst_mid_stall", {31'd0, load_use_stall}, 32'd0);
    chk("rst_mid_memread", {31'd0, ex_memread}, 32'd0);
    #1;
    rst_n = 1'b1;
    clear_inputs();
    tick();

    // ---------------- random traffic vs model ----------------
    m = empty_slot();
    for (int n = 0; n < 400; n++) begin
      hold = ($urandom_range(0, 7) == 0); flush = ($urandom_range(0, 9) == 0);
      id_valid = ($urandom_range(0, 4) != 0); id_alu_ctl = 4'($urandom_range(0, 6));
      id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
      id_alusrc = 1'($urandom); id_uses_rt = 1'($urandom);
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3)); id_rd = 5'($urandom_range(0, 3));
      id_regwrite = 1'($urandom); id_memread = ($urandom_range(0, 2) == 0);
      id_memwrite = 1'($urandom); id_memtoreg = 1'($urandom);
      exmem_regwrite = 1'($urandom); exmem_rd = 5'($urandom_range(0, 3)); exmem_result = $urandom;
      memwb_regwrite = 1'($urandom); memwb_rd = 5'($urandom_range(0, 3)); memwb_result = $urandom;
      settle();
      chk("r_stall", {31'd0, load_use_stall}, {31'd0, model_stall()});
      chk("r_valid", {31'd0, ex_valid}, {31'd0, m.valid});
      chk("r_ctl", {28'd0, ex_alu_ctl}, {28'd0, m.op});
      chk("r_rd", {27'd0, ex_rd}, {27'd0, m.rd});
      chk("r_flags", {28'd0, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg},
          {28'd0, m.rw, m.mr, m.mw, m.mtr});
      chk("r_a", ex_a, model_fwd(m.rs, m.rsd));
      chk("r_store", ex_store_data, model_fwd(m.rt, m.rtd));
      chk("r_b", ex_b, m.src ? m.imm : model_fwd(m.rt, m.rtd));
      if (flush || model_stall()) begin
        m = empty_slot();
      end else if (!hold) begin
        m = '{valid: id_valid, op: id_alu_ctl, src: id_alusrc,
              rw: id_regwrite & id_valid, mr: id_memread & id_valid,
              mw: id_memwrite & id_valid, mtr: id_memtoreg & id_valid,
              rd: id_rd, rs: id_rs, rt: id_rt,
              rsd: id_rs_data, rtd: id_rt_data, imm: id_imm};
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
